// File: rtl/phy_mgmt_pkg.sv
// phy_mgmt_pkg: sequencer state encoding, init-table entry format and the default PHY init table
package phy_mgmt_pkg;
    typedef enum logic [2:0] {
        PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, POLL_ISSUE, POLL_WAIT, HOST_ISSUE, HOST_WAIT
    } state_e;
    localparam int INIT_ENTRY_W = 21;
    typedef logic [INIT_ENTRY_W-1:0] init_entry_t;
    localparam logic MDIO_RD = 1'b1;
    localparam logic MDIO_WR = 1'b0;
    // {addr[20:16], data[15:0]}: soft reset, AN enable, advertise, 1000BASE-T control
    function automatic init_entry_t init_table(input logic [3:0] idx);
        case (idx)
            4'd0:    return {5'd0, 16'h8000};
            4'd1:    return {5'd0, 16'h1140};
            4'd2:    return {5'd4, 16'h01E1};
            4'd3:    return {5'd9, 16'h0000};
            default: return '0;
        endcase
    endfunction
endpackage

// File: rtl/phy_init_rom.sv
// phy_init_rom: combinational index -> {addr, data} lookup over the package init table
import phy_mgmt_pkg::*;
module phy_init_rom (
    input  logic [3:0]  idx,
    output logic [4:0]  addr,
    output logic [15:0] data
);
    assign {addr, data} = init_table(idx);
endmodule

// File: rtl/phy_mgmt_ctrl.sv
// phy_mgmt_ctrl: power-up/init sequencer, link poller and host arbiter in front of the MDIO engine
// PHY_MGMT_TIMEOUT_EN adds a watchdog that aborts any *_WAIT after TIMEOUT_CYCLES and pulses mgmt_err.
import phy_mgmt_pkg::*;
module phy_mgmt_ctrl #(
    parameter int          INIT_DEPTH     = 4,
    parameter logic [15:0] PWR_UP_DELAY   = 16'd50000,
    parameter logic [23:0] POLL_INTERVAL  = 24'd1000000,
    parameter logic [4:0]  STATUS_REG     = 5'd1,
    parameter int          LINK_BIT       = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [4:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        mdio_req,
    output logic        mdio_rd,
    output logic [4:0]  mdio_addr,
    output logic [15:0] mdio_wdata,
    input  logic        mdio_done,
    input  logic [15:0] mdio_rdata,
    output logic        init_done,
    output logic        link_up,
    output logic        link_change,
    output logic        mgmt_err
);
    state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [23:0] tmr_q, tmr_d;
    logic tmr_en_q, tmr_en_d, poll_pending_q, poll_pending_d;
    logic mdio_req_q, mdio_req_d, mdio_rd_q, mdio_rd_d;
    logic [4:0] mdio_addr_q, mdio_addr_d;
    logic [15:0] mdio_wdata_q, mdio_wdata_d, host_rdata_q, host_rdata_d;
    logic host_ack_q, host_ack_d, init_done_q, init_done_d;
    logic link_up_q, link_up_d, link_change_q, link_change_d, mgmt_err_q, mgmt_err_d;
    logic [4:0] rom_addr;
    logic [15:0] rom_data;
    logic wait_st, timeout, fin, host_go, reload;

    phy_init_rom u_rom (.idx(idx_q), .addr(rom_addr), .data(rom_data));

    assign wait_st = state_q inside {INIT_WAIT, POLL_WAIT, HOST_WAIT};
`ifdef PHY_MGMT_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    always_comb wd_d = wait_st ? wd_q + 16'd1 : 16'd0;
    assign timeout = wait_st && !mdio_done && wd_q == TIMEOUT_CYCLES - 16'd1;
    always_ff @(posedge clk) begin
        if (rst) wd_q <= 16'd0;
        else     wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
    assign fin = wait_st && (mdio_done || timeout);
    // host_ack_q masks the host's one-cycle release window so a just-served request is not replayed
    assign host_go = host_req && !host_ack_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        mdio_req_d = mdio_req_q && !fin;
        mdio_rd_d = mdio_rd_q;
        mdio_addr_d = mdio_addr_q;
        mdio_wdata_d = mdio_wdata_q;
        host_ack_d = 1'b0;
        host_rdata_d = host_rdata_q;
        init_done_d = init_done_q;
        link_up_d = link_up_q;
        link_change_d = 1'b0;
        mgmt_err_d = timeout;
        reload = 1'b0;
        case (state_q)
            PWRUP: begin
                cnt_d = cnt_q - 16'd1;
                state_d = cnt_q == 16'd0 ? INIT_ISSUE : PWRUP;
            end
            INIT_ISSUE: begin
                {mdio_req_d, mdio_rd_d, mdio_addr_d, mdio_wdata_d} = {1'b1, MDIO_WR, rom_addr, rom_data};
                state_d = INIT_WAIT;
            end
            INIT_WAIT: if (fin) begin
                reload = idx_q == 4'(INIT_DEPTH - 1);
                init_done_d = init_done_q || reload;
                idx_d = reload ? idx_q : idx_q + 4'd1;
                state_d = reload ? IDLE : INIT_ISSUE;
            end
            IDLE: state_d = host_go ? HOST_ISSUE : poll_pending_q ? POLL_ISSUE : IDLE;
            POLL_ISSUE: begin
                {mdio_req_d, mdio_rd_d, mdio_addr_d, mdio_wdata_d} = {1'b1, MDIO_RD, STATUS_REG, 16'h0000};
                state_d = POLL_WAIT;
            end
            POLL_WAIT: if (fin) begin
                reload = 1'b1;
                link_up_d = mdio_done ? mdio_rdata[LINK_BIT] : link_up_q;
                link_change_d = mdio_done && mdio_rdata[LINK_BIT] != link_up_q;
                state_d = IDLE;
            end
            HOST_ISSUE: begin
                {mdio_req_d, mdio_rd_d, mdio_addr_d, mdio_wdata_d} = {1'b1, host_we ? MDIO_WR : MDIO_RD, host_addr, host_wdata};
                state_d = HOST_WAIT;
            end
            HOST_WAIT: if (fin) begin
                host_ack_d = 1'b1;
                host_rdata_d = mdio_done ? mdio_rdata : 16'hFFFF;
                state_d = IDLE;
            end
        endcase
        poll_pending_d = state_q == IDLE && !host_go && poll_pending_q ? 1'b0 :
                         tmr_en_q && tmr_q == 24'd0 ? 1'b1 : poll_pending_q;
        tmr_en_d = reload ? 1'b1 : tmr_q == 24'd0 ? 1'b0 : tmr_en_q;
        tmr_d = reload ? POLL_INTERVAL - 24'd1 : tmr_en_q && tmr_q != 24'd0 ? tmr_q - 24'd1 : tmr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWRUP;
            cnt_q <= PWR_UP_DELAY - 16'd1;
            idx_q <= 4'd0;
            tmr_q <= 24'd0;
            tmr_en_q <= 1'b0;
            poll_pending_q <= 1'b0;
            mdio_req_q <= 1'b0;
            mdio_rd_q <= 1'b0;
            mdio_addr_q <= 5'd0;
            mdio_wdata_q <= 16'd0;
            host_ack_q <= 1'b0;
            host_rdata_q <= 16'd0;
            init_done_q <= 1'b0;
            link_up_q <= 1'b0;
            link_change_q <= 1'b0;
            mgmt_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            tmr_q <= tmr_d;
            tmr_en_q <= tmr_en_d;
            poll_pending_q <= poll_pending_d;
            mdio_req_q <= mdio_req_d;
            mdio_rd_q <= mdio_rd_d;
            mdio_addr_q <= mdio_addr_d;
            mdio_wdata_q <= mdio_wdata_d;
            host_ack_q <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            init_done_q <= init_done_d;
            link_up_q <= link_up_d;
            link_change_q <= link_change_d;
            mgmt_err_q <= mgmt_err_d;
        end
    end

    assign mdio_req = mdio_req_q;
    assign mdio_rd = mdio_rd_q;
    assign mdio_addr = mdio_addr_q;
    assign mdio_wdata = mdio_wdata_q;
    assign host_ack = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign init_done = init_done_q;
    assign link_up = link_up_q;
    assign link_change = link_change_q;
    assign mgmt_err = mgmt_err_q;
endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// tb_phy_mgmt_ctrl: directed scenarios against phy_mgmt_ctrl with a 10-cycle MDIO engine model
module tb_phy_mgmt_ctrl;
    localparam logic [4:0] STATUS_REG = 5'd1;
    logic clk = 1'b0, rst = 1'b1;
    logic host_req, host_we, host_ack, mdio_req, mdio_rd, mdio_done, init_done, link_up, link_change, mgmt_err;
    logic [4:0] host_addr, mdio_addr;
    logic [15:0] host_wdata, host_rdata, mdio_wdata, mdio_rdata;
    logic [4:0] exp_addr [3];
    logic [15:0] exp_data [3];
    logic [15:0] poll_val = 16'h0000;
    bit model_hang = 0, model_busy = 0;
    int model_cnt = 0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    phy_mgmt_ctrl #(
        .INIT_DEPTH(3), .PWR_UP_DELAY(16'd16), .POLL_INTERVAL(24'd100),
        .STATUS_REG(STATUS_REG), .LINK_BIT(2), .TIMEOUT_CYCLES(16'd64)
    ) dut (
        .clk(clk), .rst(rst), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata), .mdio_req(mdio_req),
        .mdio_rd(mdio_rd), .mdio_addr(mdio_addr), .mdio_wdata(mdio_wdata), .mdio_done(mdio_done),
        .mdio_rdata(mdio_rdata), .init_done(init_done), .link_up(link_up), .link_change(link_change),
        .mgmt_err(mgmt_err)
    );

    // engine model: completes 10 cycles after it sees mdio_req; STATUS_REG returns poll_val, reg 2 returns 0x0022
    initial begin
        mdio_done = 1'b0;
        mdio_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mdio_done = 1'b0;
            if (rst) model_busy = 0;
            else if (!model_busy) begin
                if (mdio_req) begin
                    model_busy = 1;
                    model_cnt = 0;
                end
            end else if (!mdio_req) model_busy = 0;
            else begin
                model_cnt++;
                if (model_cnt == 10 && !model_hang) begin
                    mdio_done = 1'b1;
                    mdio_rdata = mdio_addr == STATUS_REG ? poll_val : mdio_addr == 5'd2 ? 16'h0022 : 16'h0000;
                    model_busy = 0;
                end
            end
        end
    end

    task automatic run_init();
        int nreq = 0, first_req = -1, done_edge = -1, k;
        bit prev_req = 0, ack_early = 0, err_seen = 0;
        for (k = 1; k <= 400; k++) begin
            @(posedge clk);
            #2;
            if (mgmt_err) err_seen = 1;
            if (host_ack && !init_done) ack_early = 1;
            if (init_done) break;
            if (mdio_req && !prev_req) begin
                if (nreq == 0) first_req = k;
                if (nreq < 3) begin
                    checks++;
                    if ({mdio_rd, mdio_addr, mdio_wdata} !== {1'b0, exp_addr[nreq], exp_data[nreq]}) begin
                        errors++;
                        $display("FAIL init_frame%0d: got rd=%0b addr=%0d data=%h, expected rd=0 addr=%0d data=%h",
                                 nreq, mdio_rd, mdio_addr, mdio_wdata, exp_addr[nreq], exp_data[nreq]);
                    end
                end
                nreq++;
            end
            prev_req = mdio_req;
            if (mdio_done) done_edge = k + 1;
        end
        checks++;
        if (init_done !== 1'b1 || k != done_edge) begin
            errors++;
            $display("FAIL init_done_timing: init_done=%b at edge %0d, expected 1 at edge %0d", init_done, k, done_edge);
        end
        checks++;
        if (first_req != 17) begin
            errors++;
            $display("FAIL first_req_edge: got %0d, expected 17 (16 cycles after first rst-low edge)", first_req);
        end
        checks++;
        if (nreq != 3) begin
            errors++;
            $display("FAIL init_frame_count: got %0d, expected 3", nreq);
        end
        checks++;
        if (ack_early || err_seen) begin
            errors++;
            $display("FAIL init_quiet: host_ack_before_init=%0b mgmt_err=%0b, expected 0 0", ack_early, err_seen);
        end
    endtask

    task automatic poll_step(input logic exp_link, input logic exp_change);
        bit found = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (mdio_done && mdio_rd && mdio_addr == STATUS_REG) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL poll_wait: no status poll completed within 300 cycles");
        end
        @(posedge clk);
        #2;
        checks++;
        if ({link_up, link_change} !== {exp_link, exp_change}) begin
            errors++;
            $display("FAIL poll_link: got link_up=%b link_change=%b, expected %b %b", link_up, link_change, exp_link, exp_change);
        end
        @(posedge clk);
        #2;
        checks++;
        if (link_change !== 1'b0) begin
            errors++;
            $display("FAIL link_change_pulse: got %b one cycle later, expected 0", link_change);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({mdio_req, host_ack, link_change, mgmt_err, init_done, link_up} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req/ack/chg/err/done/link=%b, expected 000000",
                     {mdio_req, host_ack, link_change, mgmt_err, init_done, link_up});
        end
        checks++;
        if ({mdio_rd, mdio_addr, mdio_wdata, host_rdata} !== 38'd0) begin
            errors++;
            $display("FAIL reset_data: got rd=%b addr=%0d wdata=%h rdata=%h, expected all 0", mdio_rd, mdio_addr, mdio_wdata, host_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_init_with_host();
        bit seen = 0, ack = 0;
        logic [5:0] frame = 6'd0;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 5'd2;
        run_init();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (mdio_req && !seen) begin
                seen = 1;
                frame = {mdio_rd, mdio_addr};
            end
            if (host_ack) begin
                ack = 1;
                break;
            end
        end
        host_req = 1'b0;
        checks++;
        if (!ack || host_rdata !== 16'h0022) begin
            errors++;
            $display("FAIL host_read: ack=%0b rdata=%h, expected ack=1 rdata=0022", ack, host_rdata);
        end
        checks++;
        if (frame !== {1'b1, 5'd2} || link_up !== 1'b0) begin
            errors++;
            $display("FAIL host_frame: got rd/addr=%b link_up=%b, expected 1/2 link_up=0", frame, link_up);
        end
    endtask

    task automatic test_poll();
        poll_val = 16'h0004;
        poll_step(1'b1, 1'b1);
        poll_step(1'b1, 1'b0);
        poll_val = 16'h0000;
        poll_step(1'b0, 1'b1);
    endtask

    task automatic test_collision();
        bit ack = 0;
        poll_val = 16'h0004;
        repeat (99) @(posedge clk);
        #2;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = STATUS_REG;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (host_ack) begin
                ack = 1;
                break;
            end
        end
        host_req = 1'b0;
        checks++;
        if (!ack || host_rdata !== 16'h0004 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL collide_host_first: ack=%0b rdata=%h link_up=%b, expected 1 0004 0", ack, host_rdata, link_up);
        end
        @(posedge clk);
        #2;
        checks++;
        if (mdio_req !== 1'b0) begin
            errors++;
            $display("FAIL collide_gap: mdio_req=%b, expected 0", mdio_req);
        end
        @(posedge clk);
        #2;
        checks++;
        if ({mdio_req, mdio_rd, mdio_addr} !== {1'b1, 1'b1, STATUS_REG}) begin
            errors++;
            $display("FAIL collide_poll_issue: req=%b rd=%b addr=%0d, expected 1 1 %0d", mdio_req, mdio_rd, mdio_addr, STATUS_REG);
        end
        poll_step(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_poll();
        bit found = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (mdio_req && mdio_rd && mdio_addr == STATUS_REG) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midpoll_wait: no poll frame seen within 300 cycles");
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if ({mdio_req, init_done, link_up} !== 3'b000) begin
            errors++;
            $display("FAIL midpoll_reset: req/init_done/link_up=%b, expected 000", {mdio_req, init_done, link_up});
        end
        rst = 1'b0;
        run_init();
    endtask

`ifdef PHY_MGMT_TIMEOUT_EN
    task automatic test_timeout();
        int rise = -1, fall = -1;
        model_hang = 1;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 5'd3;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #2;
            if (rise < 0 && mdio_req) rise = k;
            else if (rise >= 0 && !mdio_req) begin
                fall = k;
                break;
            end
        end
        checks++;
        if (rise < 0 || fall - rise != 64) begin
            errors++;
            $display("FAIL timeout_len: req rise=%0d fall=%0d, expected fall-rise=64", rise, fall);
        end
        checks++;
        if ({mgmt_err, host_ack, host_rdata} !== {1'b1, 1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL timeout_abort: mgmt_err=%b ack=%b rdata=%h, expected 1 1 ffff", mgmt_err, host_ack, host_rdata);
        end
        host_req = 1'b0;
        model_hang = 0;
        @(posedge clk);
        #2;
        checks++;
        if (mgmt_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: mgmt_err=%b one cycle later, expected 0", mgmt_err);
        end
    endtask
`endif

    initial begin
        exp_addr[0] = 5'd0;
        exp_addr[1] = 5'd0;
        exp_addr[2] = 5'd4;
        exp_data[0] = 16'h8000;
        exp_data[1] = 16'h1140;
        exp_data[2] = 16'h01E1;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = 5'd0;
        host_wdata = 16'h0000;
        test_reset();
        test_init_with_host();
        test_poll();
        test_collision();
        test_reset_mid_poll();
`ifdef PHY_MGMT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phy_mgmt_ctrl.md
# phy_mgmt_ctrl

Sequencer and arbiter in front of the MDIO master engine. After reset it waits out the PHY power-up delay, then writes an init table of PHY registers. It then polls the PHY status register periodically to track link state, and shares the engine with a host register-access port. It is the only block that drives the engine's request interface.

## Interface
Parameters:
- INIT_DEPTH, 4: number of init-table entries written after reset (1..16).
- PWR_UP_DELAY, 16'd50000: clk cycles between reset release and first init write.
- POLL_INTERVAL, 24'd1000000: clk cycles between status polls, measured from poll completion.
- STATUS_REG, 5'd1: PHY register polled for link.
- LINK_BIT, 2: bit of STATUS_REG giving link state.
- TIMEOUT_CYCLES, 16'd256: MDIO watchdog limit. Used only with PHY_MGMT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; also the engine clock.
- rst  in  1  reset: synchronous, active-high.
- host_req  in  1  host access request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  5  PHY register address.
- host_wdata  in  16  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  16  read data; valid with host_ack and held until the next host_ack.
- mdio_req  out  1  engine request; level, held until mdio_done.
- mdio_rd  out  1  1 = read frame, 0 = write frame.
- mdio_addr  out  5  register address to engine.
- mdio_wdata  out  16  write data to engine.
- mdio_done  in  1  engine one-cycle completion pulse.
- mdio_rdata  in  16  read data; valid with mdio_done.
- init_done  out  1  high once all init writes are complete.
- link_up  out  1  last polled value of STATUS_REG[LINK_BIT].
- link_change  out  1  one-cycle pulse when link_up toggles.
- mgmt_err  out  1  one-cycle watchdog-abort pulse. Tied 0 without PHY_MGMT_TIMEOUT_EN.

## Operation
- States:
  - PWRUP → INIT_ISSUE → INIT_WAIT → (next entry or IDLE).
  - IDLE → POLL_ISSUE/POLL_WAIT or HOST_ISSUE/HOST_WAIT → IDLE.
- PWRUP: a down-counter is loaded with PWR_UP_DELAY-1 and runs to 0.
- INIT: entries 0..INIT_DEPTH-1 from the init ROM are sent as writes, in order, one at a time. init_done is set the cycle after the last mdio_done and stays set until rst.
- Host requests seen before init_done are held pending and are not acknowledged. They are served from IDLE.
- Poll timer: a down-counter reloaded with POLL_INTERVAL-1 when init completes and after each poll completes.
  - At 0 it sets poll_pending and stops.
  - poll_pending clears when POLL_ISSUE is entered.
- Arbitration in IDLE:
  - host_req has priority over poll_pending.
  - A pending poll is kept, never dropped, and issues right after the host transaction.
- Poll completion: link_up <= mdio_rdata[LINK_BIT]. link_change pulses if the new value differs from the old one.
- Host reads of STATUS_REG do not update link_up.
- Only one engine transaction is outstanding at any time.

## Timing
- Reset values:
  - mdio_req, host_ack, link_change, mgmt_err, init_done, link_up = 0.
  - mdio_rd = 0; mdio_addr = 0; mdio_wdata = 0; host_rdata = 0.
  - State = PWRUP.
- mdio_req rises on the cycle after an *_ISSUE state is entered. mdio_rd, mdio_addr and mdio_wdata are registered and stable from that cycle until mdio_done.
- mdio_req falls on the cycle after mdio_done is sampled. The next request can rise no earlier than 1 cycle later, so there is at least one low cycle between frames.
- host_ack is registered and pulses the cycle after mdio_done. host_req must drop the cycle after host_ack; a still-high host_req is treated as a new request.
- mdio_done outside a *_WAIT state is ignored.
- rst at any time, including mid-frame:
  - All outputs go to reset values on the next edge and the sequence restarts at PWRUP.
  - The engine shares rst.

## Configuration
- PHY_MGMT_TIMEOUT_EN defined:
  - A watchdog counts cycles in every *_WAIT state.
  - On reaching TIMEOUT_CYCLES, mdio_req drops and mgmt_err pulses.
  - INIT: the sequence advances to the next entry.
  - HOST: host_ack pulses with host_rdata = 16'hFFFF.
  - POLL: link_up is unchanged and the timer reloads.
- Not defined: no watchdog; *_WAIT waits indefinitely; mgmt_err is tied 0.

## Structure
- Package phy_mgmt_pkg holds:
  - state encodings;
  - the init-table entry width (21 bits: addr[20:16], data[15:0]);
  - the default init table: {0, 16'h8000} reset, {0, 16'h1140} AN enable, {4, 16'h01E1} advertise, {9, 16'h0000};
  - opcode constants (MDIO_RD = 1, MDIO_WR = 0).
- Sub-module phy_init_rom: combinational index → {addr, data} lookup over the package table.

## Test plan
- PWR_UP_DELAY=16, INIT_DEPTH=3, engine model done after 10 cycles:
  - first mdio_req (wr, addr 0, 16'h8000) 16 cycles after rst drops;
  - three writes in table order;
  - init_done rises 1 cycle after the third mdio_done.
- POLL_INTERVAL=100, model returns 16'h0004 then 16'h0000: link_up goes 1 then 0, with one link_change pulse at each transition.
- Host read addr 2 issued during init: no host_ack before init_done; then host_ack with host_rdata = model value 16'h0022; link_up unchanged.
- host_req and poll-timer expiry in the same IDLE cycle: host frame first, then the poll frame with mdio_addr = STATUS_REG issues immediately after.
- PHY_MGMT_TIMEOUT_EN, TIMEOUT_CYCLES=64, model never completes a host read:
  - mdio_req drops 64 cycles after rising;
  - mgmt_err pulses;
  - host_ack with 16'hFFFF.
- rst pulsed during POLL_WAIT: next cycle mdio_req=0, init_done=0, link_up=0; init sequence replays after PWR_UP_DELAY.
